mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, the maximum consecutive cycles waited for mem_ready before abort (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Op, input, 6, the opcode field of the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory access-complete handshake.
REQ-006 SHALL have ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, each output, 1, datapath strobes and selects.
REQ-007 SHALL have ports ALUSrcB, PCSource, ALUOp, each output, 2; ALUOp is the code consumed by the ALU control decoder.
REQ-008 SHALL have port illegal, output, 1, one-cycle pulse on an undecodable opcode.
REQ-009 SHALL have port timeout, output, 1, one-cycle pulse on a memory-wait abort.
REQ-010 SHALL have port state, output, 4, current FSM state for debug.

Function
REQ-011 SHALL use ALUOp codes 2'b00 add (lw/sw, PC arithmetic), 2'b01 subtract (beq), 2'b10 R-type funct decode; 2'b11 SHALL never be driven.
REQ-012 SHALL use a registered state with encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9.
REQ-013 SHALL decode outputs combinationally from state and mem_ready; every output not listed for a state SHALL be 0.
REQ-014 In FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; when mem_ready=1, IRWrite=1, PCWrite=1 and the next state is DECODE; otherwise hold.
REQ-015 In DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state is EXEC for Op 6'h00, MEMADR for 6'h23 or 6'h2b, BRANCH for 6'h04, JUMP for 6'h02 (see REQ-026); any other Op pulses illegal and the next state is FETCH.
REQ-016 In MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state is MEMRD for 6'h23, MEMWR for 6'h2b; Op is sampled in this state, not latched.
REQ-017 In MEMRD: IorD=1, MemRead=1; next state is MEMWB on mem_ready, otherwise hold.
REQ-018 In MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next state is FETCH.
REQ-019 In MEMWR: IorD=1, MemWrite=1; next state is FETCH on mem_ready, otherwise hold.
REQ-020 In EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state is RWB. In RWB: RegDst=1, MemtoReg=0, RegWrite=1; next state is FETCH.
REQ-021 In BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state is FETCH.
REQ-022 SHALL maintain an 8-bit wait counter that clears on every state change and increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
REQ-023 When the wait counter equals MEM_TIMEOUT-1 and mem_ready=0, the block SHALL pulse timeout, suppress IRWrite, PCWrite and MemWrite for that cycle, and make FETCH the next state; mem_ready=1 in that same cycle SHALL win (normal completion, no timeout).
REQ-024 Unreachable encodings 10..15 SHALL transition to FETCH with all outputs 0.

Reset
REQ-025 While rst=1 at a clock edge, state SHALL become FETCH and the wait counter 0; reset mid-operation (any state, including wait states) SHALL abandon the instruction with no further strobes, and illegal/timeout SHALL be 0 during reset.

Configuration
REQ-026 Macro JUMP_EN: when defined, Op 6'h02 in DECODE SHALL go to JUMP, which drives PCWrite=1 and PCSource=10 and then goes to FETCH; when undefined, the JUMP state SHALL not exist and 6'h02 SHALL be treated as illegal per REQ-015.

Verification
REQ-027 lw (Op=6'h23), mem_ready held 1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; five cycles per instruction.
REQ-028 R-type (Op=6'h00) -> states 0,1,6,7,0; ALUOp=10 in EXEC; RegDst=1 and RegWrite=1 in RWB.
REQ-029 beq (Op=6'h04) -> states 0,1,8,0; PCWriteCond=1, ALUOp=01, PCSource=01 in BRANCH.
REQ-030 sw with mem_ready=0 in MEMWR for 15 cycles (MEM_TIMEOUT=16) -> timeout pulses on the 16th cycle, MemWrite=0 on that cycle, next state FETCH.
REQ-031 Op=6'h02 -> with JUMP_EN: states 0,1,9,0 with PCWrite=1 in JUMP; without JUMP_EN: illegal=1 in DECODE, next state FETCH.
REQ-032 rst=1 asserted during MEMRD -> state=0 next cycle with all strobes 0; normal fetch resumes after rst=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-style main controller: state register, memory-wait timeout, decoded strobes.
// Optional JUMP_EN adds the JUMP state for opcode 6'h02; otherwise that opcode is illegal.
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] state
);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpBeq   = 6'h04;
`ifdef JUMP_EN
  localparam logic [5:0] OpJ     = 6'h02;
`endif

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8
`ifdef JUMP_EN
    , StJump = 4'd9
`endif
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       illegal;
    logic       timeout;
  } ctrl_t;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  ctrl_t      ctrl;
  logic       expired;
  logic       waiting;
  logic       abort;

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    waiting = 1'b0;
    abort   = 1'b0;
    expired = !mem_ready && (cnt_q == WaitLast);

    case (state_q)
      StFetch: begin
        waiting        = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = StDecode;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = StFetch;
        end
      end
      StDecode: begin
        ctrl.alu_src_b = 2'b11;
        case (Op)
          OpRtype:     state_d = StExec;
          OpLw, OpSw:  state_d = StMemAdr;
          OpBeq:       state_d = StBranch;
`ifdef JUMP_EN
          OpJ:         state_d = StJump;
`endif
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        // Op is looked at live here; anything but a load/store abandons the instruction.
        if (Op == OpLw)      state_d = StMemRd;
        else if (Op == OpSw) state_d = StMemWr;
        else                 state_d = StFetch;
      end
      StMemRd: begin
        waiting       = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = StFetch;
        end
      end
      StMemWb: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        state_d         = StFetch;
      end
      StMemWr: begin
        waiting        = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.mem_write = !expired;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d        = StRwb;
      end
      StRwb: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = StFetch;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        state_d            = StFetch;
      end
`ifdef JUMP_EN
      StJump: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        state_d        = StFetch;
      end
`endif
      default: state_d = StFetch;
    endcase

    ctrl.timeout = abort;
    if (rst) ctrl = '0;

    // A timeout restarts the wait even though FETCH may be re-entered from FETCH.
    if (state_d != state_q || abort) cnt_d = '0;
    else if (waiting && !mem_ready)  cnt_d = cnt_q + 8'd1;
    else                             cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUOp       = ctrl.alu_op;
  assign illegal     = ctrl.illegal;
  assign timeout     = ctrl.timeout;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed literal sequences plus randomized traffic
// compared every cycle against a table-driven behavioural model.
module tb_mc_ctrl;

  localparam int MemTimeout = 16;
`ifdef JUMP_EN
  localparam bit JumpEn = 1'b1;
`else
  localparam bit JumpEn = 1'b0;
`endif

  // Output vector layout: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
  // RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], PCSource[1:0], ALUOp[1:0], illegal, timeout}
  localparam logic [17:0] MPcWrite  = 18'h20000;
  localparam logic [17:0] MPcCond   = 18'h10000;
  localparam logic [17:0] MIorD     = 18'h08000;
  localparam logic [17:0] MMemRead  = 18'h04000;
  localparam logic [17:0] MMemWrite = 18'h02000;
  localparam logic [17:0] MIrWrite  = 18'h01000;
  localparam logic [17:0] MMemToReg = 18'h00800;
  localparam logic [17:0] MRegDst   = 18'h00400;
  localparam logic [17:0] MRegWrite = 18'h00200;
  localparam logic [17:0] MSrcA     = 18'h00100;
  localparam logic [17:0] MIllegal  = 18'h00002;
  localparam logic [17:0] MTimeout  = 18'h00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] Op = 6'h00;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
  logic       RegWrite, ALUSrcA, illegal, timeout;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  int m_state = 0;
  int m_wait  = 0;
  bit m_valid = 1'b0;

  mc_ctrl #(.MEM_TIMEOUT(MemTimeout)) dut (
    .clk(clk), .rst(rst), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .illegal(illegal), .timeout(timeout), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] dut_vec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
            RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal, timeout};
  endfunction

  function automatic bit op_legal(logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 || (JumpEn && op == 6'h02);
  endfunction

  function automatic bit is_wait_state(int st);
    return st == 0 || st == 3 || st == 5;
  endfunction

  // Expected outputs: fixed per-state pattern, then the mem_ready/timeout/opcode-dependent bits.
  function automatic logic [17:0] model_out(int st, logic [5:0] op, bit rdy, bit r, int waited);
    logic [17:0] v;
    bit          expire;
    expire = is_wait_state(st) && !rdy && waited == MemTimeout - 1;
    case (st)
      0: v = MMemRead | (18'd1 << 6) | (rdy ? (MIrWrite | MPcWrite) : 18'd0);
      1: v = (18'd3 << 6) | (op_legal(op) ? 18'd0 : MIllegal);
      2: v = MSrcA | (18'd2 << 6);
      3: v = MIorD | MMemRead;
      4: v = MMemToReg | MRegWrite;
      5: v = MIorD | (expire ? 18'd0 : MMemWrite);
      6: v = MSrcA | (18'd2 << 2);
      7: v = MRegDst | MRegWrite;
      8: v = MSrcA | (18'd1 << 2) | MPcCond | (18'd1 << 4);
      9: v = MPcWrite | (18'd2 << 4);
      default: v = 18'd0;
    endcase
    if (expire) v = v | MTimeout;
    if (r) v = 18'd0;
    return v;
  endfunction

  function automatic int model_next(int st, logic [5:0] op, bit rdy, int waited);
    bit expire;
    expire = !rdy && waited == MemTimeout - 1;
    case (st)
      0: return rdy ? 1 : 0;
      1: begin
        if (op == 6'h00) return 6;
        if (op == 6'h23 || op == 6'h2b) return 2;
        if (op == 6'h04) return 8;
        if (JumpEn && op == 6'h02) return 9;
        return 0;
      end
      2: return (op == 6'h23) ? 3 : (op == 6'h2b) ? 5 : 0;
      3: return rdy ? 4 : (expire ? 0 : 3);
      4: return 0;
      5: return (rdy || expire) ? 0 : 5;
      6: return 7;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Apply inputs mid-cycle and compare against the model.
  task automatic drive(input bit r, input logic [5:0] op, input bit rdy);
    rst = r;
    Op = op;
    mem_ready = rdy;
    #1;
    if (m_valid) begin
      chk("model_outputs", 32'(dut_vec()), 32'(model_out(m_state, op, rdy, r, m_wait)));
      chk("model_state", 32'(state), 32'(m_state));
    end
  endtask

  task automatic tick();
    int  nxt;
    bit  expire;
    @(posedge clk);
    if (rst) begin
      m_state = 0;
      m_wait  = 0;
      m_valid = 1'b1;
    end else begin
      expire = is_wait_state(m_state) && !mem_ready && m_wait == MemTimeout - 1;
      nxt = model_next(m_state, Op, mem_ready, m_wait);
      if (nxt != m_state || expire)                 m_wait = 0;
      else if (is_wait_state(m_state) && !mem_ready) m_wait++;
      m_state = nxt;
    end
    @(negedge clk);
  endtask

  // Run one instruction with mem_ready=1, checking literal states and output vectors.
  task automatic run_seq(input string name, input logic [5:0] op, input int sts[$],
                         input logic [17:0] vecs[$]);
    foreach (sts[i]) begin
      drive(1'b0, op, 1'b1);
      chk({name, "_state"}, 32'(state), 32'(sts[i]));
      chk({name, "_vec"}, 32'(dut_vec()), 32'(vecs[i]));
      tick();
    end
  endtask

  task automatic to_mem(input logic [5:0] op);
    drive(1'b0, op, 1'b1); tick();
    drive(1'b0, op, 1'b1); tick();
    drive(1'b0, op, 1'b1); tick();
  endtask

  initial begin
    int mode;
    bit r;
    bit rdy;
    logic [5:0] op;
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h3f};

    @(negedge clk);
    drive(1'b1, 6'h00, 1'b0); tick();
    drive(1'b1, 6'h00, 1'b0);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    tick();

    run_seq("lw", 6'h23, '{0, 1, 2, 3, 4, 0},
            '{18'h25040, 18'h000c0, 18'h00180, 18'h0c000, 18'h00a00, 18'h25040});
    run_seq("rtype", 6'h00, '{1, 6, 7, 0},
            '{18'h000c0, 18'h00108, 18'h00600, 18'h25040});
    run_seq("beq", 6'h04, '{1, 8, 0}, '{18'h000c0, 18'h10114, 18'h25040});
    if (JumpEn) run_seq("jump", 6'h02, '{1, 9, 0}, '{18'h000c0, 18'h20020, 18'h25040});
    else        run_seq("jump_illegal", 6'h02, '{1, 0}, '{18'h000c2, 18'h25040});

    // Store stalls until the wait limit expires.
    drive(1'b0, 6'h2b, 1'b1); tick();
    drive(1'b0, 6'h2b, 1'b1); tick();
    for (int i = 1; i <= MemTimeout; i++) begin
      drive(1'b0, 6'h2b, 1'b0);
      chk("sw_wait_state", 32'(state), 32'd5);
      chk("sw_wait_vec", 32'(dut_vec()), (i == MemTimeout) ? 32'h08001 : 32'h0a000);
      tick();
    end
    drive(1'b0, 6'h2b, 1'b0);
    chk("sw_timeout_next", 32'(state), 32'd0);
    chk("fetch_wait_vec", 32'(dut_vec()), 32'h04040);

    // Fetch stalls: this is cycle 1 of the wait, timeout on cycle 16, then a fresh wait.
    for (int i = 1; i <= MemTimeout + 1; i++) begin
      if (i > 1) drive(1'b0, 6'h23, 1'b0);
      chk("fetch_timeout", 32'(timeout), (i == MemTimeout) ? 32'd1 : 32'd0);
      tick();
    end

    // Load: mem_ready arriving on the last allowed cycle completes normally.
    to_mem(6'h23);
    for (int i = 1; i <= MemTimeout; i++) begin
      drive(1'b0, 6'h23, i == MemTimeout);
      chk("lw_late_timeout", 32'(timeout), 32'd0);
      tick();
    end
    drive(1'b0, 6'h23, 1'b1);
    chk("lw_late_state", 32'(state), 32'd4);
    tick();

    // Reset in the middle of a load wait.
    to_mem(6'h23);
    drive(1'b0, 6'h23, 1'b0); tick();
    drive(1'b1, 6'h23, 1'b0);
    chk("rst_memrd_vec", 32'(dut_vec()), 32'd0);
    tick();
    drive(1'b1, 6'h23, 1'b0);
    chk("rst_memrd_state", 32'(state), 32'd0);
    chk("rst_memrd_strobes", 32'(dut_vec()), 32'd0);
    tick();
    drive(1'b0, 6'h23, 1'b1);
    chk("rst_resume_vec", 32'(dut_vec()), 32'h25040);
    tick();
    drive(1'b0, 6'h23, 1'b1);
    chk("rst_resume_state", 32'(state), 32'd1);
    tick();

    // Randomized traffic; opcode only changes while fetching.
    op = 6'h23;
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) mode = $urandom_range(0, 3);
      if (m_state == 0) op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = $urandom_range(0, 1) == 1;
        2:       rdy = $urandom_range(0, 19) == 0;
        default: rdy = 1'b0;
      endcase
      r = $urandom_range(0, 299) == 0;
      drive(r, op, rdy);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
